// File: rtl/dft_in_pingpong.sv
// dft_in_pingpong: serial-to-frame loader with ping-pong banks for dft_16to8.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready input handshake; in_data is a signed IN_W sample
//   in_last           early end-of-frame marker (framing error if before sample 31)
//   out_valid/out_ready  frame handshake; a consume frees the presented bank
//   fa_flat/fb_flat   samples 0..15 / 16..31 of the presented frame, element n at [n*IN_W +: IN_W]
//   frame_err         one-cycle pulse when a partial frame is discarded
module dft_in_pingpong #(
    parameter int IN_W  = 8,
    parameter int FRAME = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [16*IN_W-1:0] fa_flat,
    output logic [16*IN_W-1:0] fb_flat,
    output logic               frame_err
);
    logic [IN_W-1:0] r_bank [2][FRAME];
    logic [1:0]      r_full;
    logic            r_wr_sel;
    logic            r_rd_sel;
    logic [4:0]      r_wr_cnt;
    logic            r_frame_err;
    logic            w_accept;
    logic            w_consume;
    logic            w_last_slot;

    // The fill bank can only be full when both banks hold unread frames.
    assign in_ready    = !r_full[r_wr_sel];
    assign out_valid   = r_full[r_rd_sel];
    assign frame_err   = r_frame_err;
    assign w_accept    = in_valid && in_ready;
    assign w_consume   = out_valid && out_ready;
    assign w_last_slot = r_wr_cnt == 5'(FRAME - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < FRAME; i++)
                    r_bank[b][i] <= '0;
            r_full      <= '0;
            r_wr_sel    <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_wr_cnt    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_accept && in_last && !w_last_slot;
            // Consume and fill always target different banks, so both updates can land.
            if (w_consume) begin
                r_full[r_rd_sel] <= 1'b0;
                r_rd_sel         <= !r_rd_sel;
            end
            if (w_accept) begin
                r_bank[r_wr_sel][r_wr_cnt] <= in_data;
                if (w_last_slot) begin
                    r_full[r_wr_sel] <= 1'b1;
                    r_wr_sel         <= !r_wr_sel;
                    r_wr_cnt         <= '0;
                end else begin
                    // An early in_last drops the partial frame by restarting the fill.
                    r_wr_cnt <= in_last ? 5'd0 : r_wr_cnt + 5'd1;
                end
            end
        end
    end

    for (genvar n = 0; n < 16; n++) begin : g_out
        assign fa_flat[n*IN_W +: IN_W] = r_bank[r_rd_sel][n];
        assign fb_flat[n*IN_W +: IN_W] = r_bank[r_rd_sel][n+16];
    end
endmodule

// File: tb/tb_dft_in_pingpong.sv
// tb_dft_in_pingpong: randomized and directed checks of dft_in_pingpong against a frame-queue model.
module tb_dft_in_pingpong;
    localparam int IN_W = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [IN_W-1:0]    in_data = '0;
    logic               in_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [16*IN_W-1:0] fa_flat;
    logic [16*IN_W-1:0] fb_flat;
    logic               frame_err;

    dft_in_pingpong #(.IN_W(IN_W), .FRAME(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .fa_flat(fa_flat), .fb_flat(fb_flat), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_cyc = 0;

    // Model: completed frames waiting in order (at most two), plus the frame being assembled.
    logic [32*IN_W-1:0] m_q[$];
    logic [32*IN_W-1:0] m_part = '0;
    int                 m_cnt = 0;
    logic               m_err = 1'b0;
    logic               m_acc = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_part = '0;
        m_cnt  = 0;
        m_err  = 1'b0;
        m_acc  = 1'b0;
    endtask

    task automatic model_update();
        logic cons;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_acc = in_valid && (m_q.size() < 2);
        cons  = (m_q.size() > 0) && out_ready;
        m_err = 1'b0;
        if (cons) void'(m_q.pop_front());
        if (m_acc) begin
            m_part[m_cnt*IN_W +: IN_W] = in_data;
            if (m_cnt == 31) begin
                m_q.push_back(m_part);
                m_cnt = 0;
            end else if (in_last) begin
                m_cnt = 0;
                m_err = 1'b1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        n_cyc++;
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] d, input logic l, input int gap_pct);
        int tries = 0;
        in_data = d;
        in_last = l;
        do begin
            in_valid = $urandom_range(99) >= gap_pct;
            cycle();
            tries++;
        end while (!m_acc && tries < 200);
        if (!m_acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: sample %h not accepted within %0d cycles", d, tries);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();
        out_ready = 1'b0;
    endtask

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        chk("in_ready", 128'(in_ready), 128'(m_q.size() < 2));
        chk("out_valid", 128'(out_valid), 128'(m_q.size() > 0));
        chk("frame_err", 128'(frame_err), 128'(m_err));
        if (m_q.size() > 0) begin
            chk("fa_flat", fa_flat, m_q[0][16*IN_W-1:0]);
            chk("fb_flat", fb_flat, m_q[0][32*IN_W-1:16*IN_W]);
        end
    end

    initial begin
        int c0;
        #12;
        chk("rst_fa", fa_flat, '0);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        rst_n = 1'b1;
        repeat (2) cycle();

        // Ramp, no consume.
        for (int i = 0; i < 32; i++) begin
            send(IN_W'(i), 1'b0, 0);
            if (i == 30) chk("ramp_not_yet_valid", 128'(out_valid), 128'(0));
        end
        chk("ramp_valid", 128'(out_valid), 128'(1));
        chk("ramp_in_ready", 128'(in_ready), 128'(1));
        chk("ramp_fa0", 128'(fa_flat[0 +: 8]), 128'(8'd0));
        chk("ramp_fa15", 128'(fa_flat[15*8 +: 8]), 128'(8'd15));
        chk("ramp_fb0", 128'(fb_flat[0 +: 8]), 128'(8'd16));
        chk("ramp_fb15", 128'(fb_flat[15*8 +: 8]), 128'(8'd31));
        drain();

        // Back-to-back frames at full rate.
        out_ready = 1'b1;
        c0 = n_cyc;
        for (int i = 0; i < 96; i++) begin
            send(IN_W'(i), 1'b0, 0);
            if (i == 63) begin
                chk("b2b_f2_fa0", 128'(fa_flat[0 +: 8]), 128'(8'd32));
                chk("b2b_f2_fb15", 128'(fb_flat[15*8 +: 8]), 128'(8'd63));
            end
        end
        chk("b2b_cycles", 128'(n_cyc - c0), 128'(96));
        cycle();
        chk("b2b_one_cycle", 128'(out_valid), 128'(0));
        drain();

        // Backpressure with both banks full.
        for (int i = 0; i < 64; i++) send(IN_W'(i < 32 ? i : 18 + i), 1'b0, 0);
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        in_data  = 8'd200;
        in_valid = 1'b1;
        repeat (2) cycle();
        chk("bp_held_fa0", 128'(fa_flat[0 +: 8]), 128'(8'd0));
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("bp_f2_fa0", 128'(fa_flat[0 +: 8]), 128'(8'd50));
        chk("bp_ready_back", 128'(in_ready), 128'(1));
        cycle();
        in_valid = 1'b0;
        for (int i = 1; i < 32; i++) send(IN_W'(200 + i), 1'b0, 0);
        drain();

        // Early in_last on sample 9.
        for (int i = 0; i < 10; i++) send(IN_W'(10 + i), i == 9, 0);
        chk("early_err_pulse", 128'(frame_err), 128'(1));
        cycle();
        chk("early_err_once", 128'(frame_err), 128'(0));
        for (int i = 0; i < 32; i++) send(IN_W'(100 + i), 1'b0, 0);
        chk("early_fa0", 128'(fa_flat[0 +: 8]), 128'(8'd100));
        chk("early_fb15", 128'(fb_flat[15*8 +: 8]), 128'(8'd131));
        out_ready = 1'b1;
        cycle();
        chk("early_single_frame", 128'(out_valid), 128'(0));
        drain();

        // Extreme signed values.
        for (int i = 0; i < 32; i++) send(i % 2 ? 8'h7f : 8'h80, 1'b0, 0);
        chk("neg_fa0", 128'(fa_flat[0 +: 8]), 128'(8'h80));
        chk("neg_fa1", 128'(fa_flat[8 +: 8]), 128'(8'h7f));
        chk("neg_fb15", 128'(fb_flat[15*8 +: 8]), 128'(8'h7f));
        drain();

        // Randomized traffic.
        repeat (1500) begin
            in_valid  = $urandom_range(3) != 0;
            in_data   = IN_W'($urandom);
            in_last   = $urandom_range(40) == 0;
            out_ready = $urandom_range(2) == 0;
            cycle();
        end
        in_last = 1'b0;
        drain();

        // Asynchronous reset mid-frame with one full bank.
        for (int i = 0; i < 52; i++) send(IN_W'(i + 1), 1'b0, 20);
        chk("ar_pre_valid", 128'(out_valid), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 128'(out_valid), 128'(0));
        chk("ar_in_ready", 128'(in_ready), 128'(1));
        chk("ar_fa", fa_flat, '0);
        chk("ar_fb", fb_flat, '0);
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) send(IN_W'(7 + i), 1'b0, 0);
        chk("ar_next_fa0", 128'(fa_flat[0 +: 8]), 128'(8'd7));
        chk("ar_next_fb0", 128'(fb_flat[0 +: 8]), 128'(8'd23));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
